inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 132 +++++++++++++
 tb/tb_inst_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: credit-limited request stream to the MMU, in-order
// response queue toward the decoder, and flush/redirect with stale-response discard.
module inst_fetch #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    QUEUE_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    ADDR_STEP    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MEM_WAIT,
    output logic                  INST_RDEN,
    output logic [ADDR_WIDTH-1:0] INST_RADDR,
    input  logic                  INST_RVALID,
    input  logic [DATA_WIDTH-1:0] INST_RDATA,
    input  logic                  FLUSH,
    input  logic [ADDR_WIDTH-1:0] FLUSH_PC,
    output logic                  OUT_VALID,
    output logic [ADDR_WIDTH-1:0] OUT_PC,
    output logic [DATA_WIDTH-1:0] OUT_INST,
    input  logic                  OUT_READY,
    output logic                  ERR
);

    localparam int                    PW      = $clog2(QUEUE_DEPTH);
    localparam int                    CW      = PW + 1;
    localparam logic [CW:0]           DEPTH_C = (CW + 1)'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(ADDR_STEP);

    logic                  rden;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  err;
    logic [CW-1:0]         q_cnt, l_cnt, d_cnt;
    logic [CW-1:0]         q_nxt, l_nxt, d_nxt;
    logic [CW:0]           credit_sum;
    logic [PW-1:0]         wr_ptr, rd_ptr;

    logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem [QUEUE_DEPTH];

    logic                  accept;
    logic                  resp_drop;
    logic                  resp_live;
    logic                  resp_err;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] resp_pc;

    assign accept    = rden & ~MEM_WAIT;
    assign resp_drop = INST_RVALID & (d_cnt != '0);
    assign resp_live = INST_RVALID & (d_cnt == '0) & (l_cnt != '0);
    assign resp_err  = INST_RVALID & (d_cnt == '0) & (l_cnt == '0);
    assign push      = resp_live & ~FLUSH;
    assign pop       = OUT_VALID & OUT_READY & ~FLUSH;

    // Live requests are consecutive since the last redirect, so the oldest one
    // sits L steps behind the next fetch address; no PC FIFO is needed.
    assign resp_pc = raddr - ADDR_WIDTH'(l_cnt) * STEP_C;

    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        q_nxt = q_cnt;
        l_nxt = l_cnt;
        d_nxt = d_cnt;
        if (FLUSH) begin
            q_nxt = '0;
            l_nxt = '0;
            d_nxt = d_cnt + l_cnt + CW'(accept) - CW'(resp_drop | resp_live);
        end else begin
            q_nxt = q_cnt + CW'(push) - CW'(pop);
            l_nxt = l_cnt + CW'(accept) - CW'(resp_live);
            d_nxt = d_cnt - CW'(resp_drop);
        end
    end

    assign credit_sum = {1'b0, q_nxt} + {1'b0, l_nxt} + {1'b0, d_nxt};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rden   <= 1'b0;
            raddr  <= RESET_VECTOR;
            err    <= 1'b0;
            q_cnt  <= '0;
            l_cnt  <= '0;
            d_cnt  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            q_cnt <= q_nxt;
            l_cnt <= l_nxt;
            d_cnt <= d_nxt;
            rden  <= (credit_sum < DEPTH_C);
            if (resp_err) begin
                err <= 1'b1;
            end
            if (FLUSH) begin
                raddr  <= FLUSH_PC;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (accept) begin
                    raddr <= raddr + STEP_C;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // NOTE: queue storage has no reset; validity is tracked solely by q_cnt.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            inst_mem[wr_ptr] <= INST_RDATA;
        end
    end

    assign INST_RDEN  = rden;
    assign INST_RADDR = raddr;
    assign OUT_VALID  = (q_cnt != '0);
    assign OUT_PC     = pc_mem[rd_ptr];
    assign OUT_INST   = inst_mem[rd_ptr];
    assign ERR        = err;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: a behavioural MMU with optional response
// holding, a pop recorder on the output side, and hand-computed expectations.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_wait = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        ready = 1'b0;
    logic        rden;
    logic [31:0] raddr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    bit          auto_mem = 1'b1;
    bit          inject   = 1'b0;
    int          accepts  = 0;

    localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;

    inst_fetch dut (
        .CLK        (clk),
        .RST        (rst),
        .MEM_WAIT   (mem_wait),
        .INST_RDEN  (rden),
        .INST_RADDR (raddr),
        .INST_RVALID(rvalid),
        .INST_RDATA (rdata),
        .FLUSH      (flush),
        .FLUSH_PC   (flush_pc),
        .OUT_VALID  (out_valid),
        .OUT_PC     (out_pc),
        .OUT_INST   (out_inst),
        .OUT_READY  (ready),
        .ERR        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Acceptances are recorded mid-cycle, i.e. with the values the next edge sees.
    always @(negedge clk) begin
        if (!rst && rden && !mem_wait) begin
            mq.push_back(raddr);
            accepts++;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && ready) begin
            got_pc.push_back(out_pc);
            got_inst.push_back(out_inst);
        end
    end

    // One-cycle memory: a request accepted at edge k is answered at edge k+1.
    always @(posedge clk) begin
        #1;
        if (auto_mem && mq.size() > 0) begin
            rvalid = 1'b1;
            rdata  = mq.pop_front() ^ DATA_KEY;
        end else if (inject) begin
            rvalid = 1'b1;
            rdata  = 32'h0000_0BAD;
            inject = 1'b0;
        end else begin
            rvalid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut(input bit rdy, input bit amem, input bit wt);
        rst      = 1'b1;
        flush    = 1'b0;
        mem_wait = wt;
        ready    = rdy;
        auto_mem = amem;
        inject   = 1'b0;
        tick();
        mq.delete();
        got_pc.delete();
        got_inst.delete();
        accepts = 0;
        tick();
        rst = 1'b0;
    endtask

    function automatic int count_below(input logic [31:0] lim);
        int n = 0;
        foreach (got_pc[i]) if (got_pc[i] < lim) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        rst = 1'b1;
        tick();
        check("rst_rden",  rden,      0);
        check("rst_raddr", raddr,     0);
        check("rst_valid", out_valid, 0);
        check("rst_err",   err,       0);

        // Streaming: one instruction per cycle, one-cycle response latency
        reset_dut(1'b1, 1'b1, 1'b0);
        tick();
        check("rel_rden",  rden,  1);
        check("rel_raddr", raddr, 0);
        tick();
        check("lat_empty", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_pc",    out_pc,    0);
        repeat (10) tick();
        check("stream_cnt", got_pc.size(), 10);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stream_pc%0d", i),   got_pc[i],   32'(4 * i));
            check($sformatf("stream_inst%0d", i), got_inst[i], 32'(4 * i) ^ DATA_KEY);
        end

        // Backpressure: queue fills after four requests
        reset_dut(1'b0, 1'b1, 1'b0);
        repeat (10) tick();
        check("full_rden",    rden,      0);
        check("full_raddr",   raddr,     32'd16);
        check("full_accepts", accepts,   4);
        check("full_valid",   out_valid, 1);
        check("full_head",    out_pc,    0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("pop1_rden",  rden,   1);
        check("pop1_raddr", raddr,  32'd16);
        check("pop1_head",  out_pc, 32'd4);
        tick();
        check("refill_raddr",   raddr,   32'd20);
        check("refill_rden",    rden,    0);
        check("refill_accepts", accepts, 5);

        // MEM_WAIT holds the pending request
        reset_dut(1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        check("wait_start", raddr, 32'h8);
        mem_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("wait_raddr%0d", i), raddr, 32'h8);
            check($sformatf("wait_rden%0d", i),  rden,  1);
        end
        mem_wait = 1'b0;
        tick();
        check("wait_release", raddr, 32'hC);

        // Flush with two live requests in flight and a pending one replaced
        reset_dut(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        mem_wait = 1'b1;
        tick();
        check("fl_inflight", accepts, 2);
        flush    = 1'b1;
        flush_pc = 32'h100;
        tick();
        flush    = 1'b0;
        mem_wait = 1'b0;
        check("fl_raddr",   raddr,   32'h100);
        check("fl_rden",    rden,    1);
        check("fl_accepts", accepts, 2);
        got_pc.delete();
        got_inst.delete();
        auto_mem = 1'b1;
        repeat (10) tick();
        check("fl_first",  got_pc[0],   32'h100);
        check("fl_second", got_pc[1],   32'h104);
        check("fl_inst",   got_inst[0], 32'h100 ^ DATA_KEY);
        check("fl_stale",  count_below(32'h100), 0);

        // Flush coincident with a response and an acceptance
        reset_dut(1'b1, 1'b1, 1'b0);
        repeat (7) tick();
        flush    = 1'b1;
        flush_pc = 32'h200;
        tick();
        flush = 1'b0;
        check("flc_clear", out_valid, 0);
        got_pc.delete();
        got_inst.delete();
        repeat (8) tick();
        check("flc_first",  got_pc[0], 32'h200);
        check("flc_second", got_pc[1], 32'h204);
        check("flc_stale",  count_below(32'h200), 0);
        check("flc_err",    err, 0);

        // Unexpected response sets sticky ERR
        reset_dut(1'b1, 1'b0, 1'b1);
        tick();
        check("err_pre", err, 0);
        inject = 1'b1;
        tick();
        tick();
        check("err_set", err, 1);
        repeat (3) tick();
        check("err_hold", err, 1);

        // Asynchronous reset mid-stream
        mem_wait = 1'b0;
        ready    = 1'b0;
        auto_mem = 1'b1;
        repeat (6) tick();
        check("arst_pre_valid", out_valid, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_rden",  rden,      0);
        check("arst_raddr", raddr,     0);
        check("arst_valid", out_valid, 0);
        check("arst_err",   err,       0);
        mq.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
